// File: rtl/core2apb_bridge.sv
// ---------------------------------------------------------------------------
// core2apb_bridge
// Converts a core/LSU request interface (req/gnt/rvalid) into a single APB3
// master transaction stream. One transaction is outstanding at a time.
// APB3 has no byte strobes, so a partial write (be != 4'hF, including 0)
// is performed as a read-modify-write: an APB read followed by an APB write
// of the byte-merged word.
//
// Optional feature macro: APB_BRIDGE_TIMEOUT_EN
//   defined   : ACCESS phases abort after TIMEOUT_CYCLES cycles of pready=0,
//               responding with err=1 and rdata=0.
//   undefined : ACCESS waits indefinitely for pready.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   data_req_i      core request, held until granted
//   data_addr_i     byte address (bits [1:0] are ignored)
//   data_we_i       1 = write
//   data_be_i       byte enables
//   data_wdata_i    write data
//   data_gnt_o      request accepted (combinational, IDLE only)
//   data_rvalid_o   one-cycle response strobe
//   data_rdata_o    read data
//   data_err_o      error flag, qualified by data_rvalid_o
//   paddr_o, pwdata_o, pwrite_o, psel_o, penable_o   APB master outputs
//   prdata_i, pready_i, pslverr_i                    APB slave response
// ---------------------------------------------------------------------------
module core2apb_bridge #(
  parameter int APB_ADDR_WIDTH = 32,
  parameter int APB_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        data_req_i,
  input  logic [APB_ADDR_WIDTH-1:0]   data_addr_i,
  input  logic                        data_we_i,
  input  logic [APB_DATA_WIDTH/8-1:0] data_be_i,
  input  logic [APB_DATA_WIDTH-1:0]   data_wdata_i,
  output logic                        data_gnt_o,
  output logic                        data_rvalid_o,
  output logic [APB_DATA_WIDTH-1:0]   data_rdata_o,
  output logic                        data_err_o,
  output logic [APB_ADDR_WIDTH-1:0]   paddr_o,
  output logic [APB_DATA_WIDTH-1:0]   pwdata_o,
  output logic                        pwrite_o,
  output logic                        psel_o,
  output logic                        penable_o,
  input  logic [APB_DATA_WIDTH-1:0]   prdata_i,
  input  logic                        pready_i,
  input  logic                        pslverr_i
);

  localparam int BE_W = APB_DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_SETUP      = 3'd1,
    S_ACCESS     = 3'd2,
    S_RMW_SETUP  = 3'd3,
    S_RMW_ACCESS = 3'd4,
    S_RESP       = 3'd5
  } state_t;

  state_t                    r_state;
  state_t                    w_next_state;
  logic [APB_ADDR_WIDTH-1:0] r_paddr;
  logic [APB_DATA_WIDTH-1:0] r_pwdata;
  logic                      r_pwrite;
  logic [BE_W-1:0]           r_be;
  logic                      r_rmw;
  logic [APB_DATA_WIDTH-1:0] r_rdata;
  logic                      r_err;
  logic                      r_psel;
  logic                      r_penable;
  logic                      r_rvalid;
  logic                      w_timeout;

  // Byte merge for the write half of an RMW: enabled bytes come from the
  // core, the rest from the word just read back.
  function automatic logic [APB_DATA_WIDTH-1:0] merge_bytes(
    input logic [APB_DATA_WIDTH-1:0] wdata,
    input logic [APB_DATA_WIDTH-1:0] rdata,
    input logic [BE_W-1:0]           be
  );
    logic [APB_DATA_WIDTH-1:0] m;
    m = rdata;
    for (int i = 0; i < BE_W; i++) begin
      m[i*8 +: 8] = be[i] ? wdata[i*8 +: 8] : rdata[i*8 +: 8];
    end
    return m;
  endfunction

`ifdef APB_BRIDGE_TIMEOUT_EN
  localparam int TMO_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [TMO_W-1:0] r_tmo_cnt;

  // ACCESS wait-state counter; cleared in the SETUP cycle preceding each ACCESS.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tmo_cnt <= '0;
    end else if ((r_state == S_SETUP) || (r_state == S_RMW_SETUP)) begin
      r_tmo_cnt <= '0;
    end else if (((r_state == S_ACCESS) || (r_state == S_RMW_ACCESS)) && !pready_i && !w_timeout) begin
      r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
    end
  end

  // pready is tested before w_timeout in the FSM, so a same-cycle pready wins.
  assign w_timeout = ((r_state == S_ACCESS) || (r_state == S_RMW_ACCESS)) &&
                     (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES));
`else
  assign w_timeout = 1'b0;
`endif

  // Grant is only possible while idle.
  assign data_gnt_o = (r_state == S_IDLE) && data_req_i;

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (data_req_i) w_next_state = S_SETUP;
        else            w_next_state = S_IDLE;
      end
      S_SETUP:     w_next_state = S_ACCESS;
      S_ACCESS: begin
        if (pready_i) begin
          if (r_rmw && !pslverr_i) w_next_state = S_RMW_SETUP;
          else                     w_next_state = S_RESP;
        end else if (w_timeout) begin
          w_next_state = S_RESP;
        end else begin
          w_next_state = S_ACCESS;
        end
      end
      S_RMW_SETUP: w_next_state = S_RMW_ACCESS;
      S_RMW_ACCESS: begin
        if (pready_i || w_timeout) w_next_state = S_RESP;
        else                       w_next_state = S_RMW_ACCESS;
      end
      S_RESP:      w_next_state = S_IDLE;
      default:     w_next_state = S_IDLE;
    endcase
  end

  // State register and registered APB/response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_paddr   <= '0;
      r_pwdata  <= '0;
      r_pwrite  <= 1'b0;
      r_be      <= '0;
      r_rmw     <= 1'b0;
      r_rdata   <= '0;
      r_err     <= 1'b0;
      r_psel    <= 1'b0;
      r_penable <= 1'b0;
      r_rvalid  <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      // psel/penable/rvalid are decoded from the next state so they line up
      // with the state they belong to without a combinational output path.
      r_psel    <= (w_next_state == S_SETUP) || (w_next_state == S_ACCESS) ||
                   (w_next_state == S_RMW_SETUP) || (w_next_state == S_RMW_ACCESS);
      r_penable <= (w_next_state == S_ACCESS) || (w_next_state == S_RMW_ACCESS);
      r_rvalid  <= (w_next_state == S_RESP);
      case (r_state)
        S_IDLE: begin
          if (data_req_i) begin
            r_paddr  <= data_addr_i & ~APB_ADDR_WIDTH'(3);
            // For an RMW, pwdata keeps the core's data during the read phase
            // and doubles as the merge source.
            r_pwdata <= data_wdata_i;
            r_pwrite <= data_we_i && (data_be_i == {BE_W{1'b1}});
            r_rmw    <= data_we_i && (data_be_i != {BE_W{1'b1}});
            r_be     <= data_be_i;
            r_err    <= 1'b0;
          end
        end
        S_ACCESS: begin
          if (pready_i) begin
            r_rdata <= prdata_i;
            r_err   <= pslverr_i;
            if (r_rmw && !pslverr_i) begin
              r_pwdata <= merge_bytes(r_pwdata, prdata_i, r_be);
              r_pwrite <= 1'b1;
            end
          end else if (w_timeout) begin
            r_rdata <= '0;
            r_err   <= 1'b1;
          end
        end
        S_RMW_ACCESS: begin
          if (pready_i) begin
            r_err <= pslverr_i;
          end else if (w_timeout) begin
            r_rdata <= '0;
            r_err   <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign paddr_o       = r_paddr;
  assign pwdata_o      = r_pwdata;
  assign pwrite_o      = r_pwrite;
  assign psel_o        = r_psel;
  assign penable_o     = r_penable;
  assign data_rvalid_o = r_rvalid;
  assign data_rdata_o  = r_rdata;
  assign data_err_o    = r_err;

endmodule

// File: tb/tb_core2apb_bridge.sv
// ---------------------------------------------------------------------------
// Testbench for core2apb_bridge (default build, timeout feature disabled).
// Expected APB transfers and core responses are queued when stimulus is
// issued; an APB slave model and a response monitor pop and compare.
// ---------------------------------------------------------------------------
module tb_core2apb_bridge;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        data_req_i;
  logic [31:0] data_addr_i;
  logic        data_we_i;
  logic [3:0]  data_be_i;
  logic [31:0] data_wdata_i;
  logic        data_gnt_o;
  logic        data_rvalid_o;
  logic [31:0] data_rdata_o;
  logic        data_err_o;
  logic [31:0] paddr_o;
  logic [31:0] pwdata_o;
  logic        pwrite_o;
  logic        psel_o;
  logic        penable_o;
  logic [31:0] prdata_i;
  logic        pready_i;
  logic        pslverr_i;

  core2apb_bridge dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .data_req_i   (data_req_i),
    .data_addr_i  (data_addr_i),
    .data_we_i    (data_we_i),
    .data_be_i    (data_be_i),
    .data_wdata_i (data_wdata_i),
    .data_gnt_o   (data_gnt_o),
    .data_rvalid_o(data_rvalid_o),
    .data_rdata_o (data_rdata_o),
    .data_err_o   (data_err_o),
    .paddr_o      (paddr_o),
    .pwdata_o     (pwdata_o),
    .pwrite_o     (pwrite_o),
    .psel_o       (psel_o),
    .penable_o    (penable_o),
    .prdata_i     (prdata_i),
    .pready_i     (pready_i),
    .pslverr_i    (pslverr_i)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] addr;
    logic        write;
    logic        chk_wdata;
    logic [31:0] wdata;
    int          waits;
    logic [31:0] rdata;
    logic        err;
  } apb_t;

  typedef struct {
    logic        chk_rdata;
    logic [31:0] rdata;
    logic        err;
    int          gnt_cyc;
    int          lat;
  } rsp_t;

  apb_t apb_q[$];
  rsp_t rsp_q[$];
  bit   hang_mode = 1'b0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic exp_apb(input logic [31:0] addr, input logic write, input logic chk_wdata,
                         input logic [31:0] wdata, input int waits,
                         input logic [31:0] rdata, input logic err);
    apb_t e;
    e.addr = addr; e.write = write; e.chk_wdata = chk_wdata; e.wdata = wdata;
    e.waits = waits; e.rdata = rdata; e.err = err;
    apb_q.push_back(e);
  endtask

  task automatic exp_rsp(input logic chk_rdata, input logic [31:0] rdata, input logic err,
                         input int g, input int lat);
    rsp_t e;
    e.chk_rdata = chk_rdata; e.rdata = rdata; e.err = err; e.gnt_cyc = g; e.lat = lat;
    rsp_q.push_back(e);
  endtask

  // APB slave model: checks address/direction/data on every ACCESS cycle,
  // inserts the requested wait states, then answers.
  apb_t cur;
  bit   loaded = 1'b0;
  int   wcnt = 0;
  always @(negedge clk) begin
    if (rst_n && psel_o && penable_o) begin
      if (!loaded) begin
        if (apb_q.size() > 0) begin
          cur    = apb_q.pop_front();
          loaded = 1'b1;
          wcnt   = cur.waits;
        end else if (!hang_mode) begin
          checks++;
          errors++;
          $display("FAIL apb_unexpected: access addr %h write %b with none expected", paddr_o, pwrite_o);
        end
      end
      if (loaded) begin
        check32("apb_addr", paddr_o, cur.addr);
        check1("apb_write", pwrite_o, cur.write);
        if (cur.chk_wdata) check32("apb_wdata", pwdata_o, cur.wdata);
        if (wcnt > 0) begin
          pready_i = 1'b0;
          wcnt--;
        end else begin
          pready_i  = 1'b1;
          prdata_i  = cur.rdata;
          pslverr_i = cur.err;
          loaded    = 1'b0;
        end
      end else begin
        // Release an unexpected access so the bench keeps moving; stay stuck in hang mode.
        pready_i  = !hang_mode;
        prdata_i  = 32'h0;
        pslverr_i = 1'b0;
      end
    end else begin
      pready_i  = 1'b0;
      pslverr_i = 1'b0;
    end
  end

  // Response monitor.
  rsp_t mon_e;
  always @(negedge clk) begin
    if (rst_n && data_rvalid_o) begin
      if (rsp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_unexpected: rvalid with rdata %h err %b, none expected", data_rdata_o, data_err_o);
      end else begin
        mon_e = rsp_q.pop_front();
        check1("rsp_err", data_err_o, mon_e.err);
        if (mon_e.chk_rdata) check32("rsp_rdata", data_rdata_o, mon_e.rdata);
        check32("rsp_latency", 32'(cyc - mon_e.gnt_cyc), 32'(mon_e.lat));
      end
    end
  end

  task automatic issue(input logic [31:0] addr, input logic we, input logic [3:0] be,
                       input logic [31:0] wdata, output int g);
    data_req_i   = 1'b1;
    data_addr_i  = addr;
    data_we_i    = we;
    data_be_i    = be;
    data_wdata_i = wdata;
    g = -1;
    for (int i = 0; i < 50 && g < 0; i++) begin
      @(negedge clk);
      if (data_gnt_o) g = cyc;
    end
    if (g < 0) begin
      checks++;
      errors++;
      $display("FAIL gnt_timeout: no grant for addr %h within 50 cycles", addr);
    end
    @(posedge clk);
    #1;
    data_req_i = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while ((rsp_q.size() != 0 || apb_q.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (rsp_q.size() != 0 || apb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: %0d responses and %0d APB transfers still pending", rsp_q.size(), apb_q.size());
      rsp_q.delete();
      apb_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int g, g1, g2;
    rst_n = 1'b0; data_req_i = 1'b0; data_addr_i = 32'h0; data_we_i = 1'b0;
    data_be_i = 4'h0; data_wdata_i = 32'h0; prdata_i = 32'h0; pready_i = 1'b0; pslverr_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check1("rst_psel", psel_o, 1'b0);
    check1("rst_penable", penable_o, 1'b0);
    check1("rst_pwrite", pwrite_o, 1'b0);
    check1("rst_rvalid", data_rvalid_o, 1'b0);
    check1("rst_err", data_err_o, 1'b0);
    check32("rst_paddr", paddr_o, 32'h0);
    check32("rst_pwdata", pwdata_o, 32'h0);
    check32("rst_rdata", data_rdata_o, 32'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Plain read, zero wait states: SETUP at c1, ACCESS at c2, rvalid at c3.
    exp_apb(32'h1A10_1008, 1'b0, 1'b0, 32'h0, 0, 32'h1234_5678, 1'b0);
    issue(32'h1A10_1008, 1'b0, 4'hF, 32'h0, g);
    exp_rsp(1'b1, 32'h1234_5678, 1'b0, g, 3);
    check1("rd_setup_psel", psel_o, 1'b1);
    check1("rd_setup_penable", penable_o, 1'b0);
    @(posedge clk);
    #1;
    check1("rd_access_psel", psel_o, 1'b1);
    check1("rd_access_penable", penable_o, 1'b1);
    wait_done(50);

    // Full write with 3 wait states; pwdata checked on every ACCESS cycle.
    exp_apb(32'h1A10_3004, 1'b1, 1'b1, 32'hCAFE_F00D, 3, 32'h0, 1'b0);
    issue(32'h1A10_3004, 1'b1, 4'hF, 32'hCAFE_F00D, g);
    exp_rsp(1'b0, 32'h0, 1'b0, g, 6);
    wait_done(50);

    // Partial write, unaligned address: RMW with merged byte 1.
    exp_apb(32'h1A10_2000, 1'b0, 1'b0, 32'h0, 0, 32'h1122_3344, 1'b0);
    exp_apb(32'h1A10_2000, 1'b1, 1'b1, 32'h1122_AB44, 0, 32'h0, 1'b0);
    issue(32'h1A10_2002, 1'b1, 4'b0010, 32'h0000_AB00, g);
    exp_rsp(1'b0, 32'h0, 1'b0, g, 5);
    wait_done(50);

    // be == 0 write: RMW that writes back the read value unchanged.
    exp_apb(32'h1A10_4010, 1'b0, 1'b0, 32'h0, 0, 32'h55AA_55AA, 1'b0);
    exp_apb(32'h1A10_4010, 1'b1, 1'b1, 32'h55AA_55AA, 1, 32'h0, 1'b0);
    issue(32'h1A10_4010, 1'b1, 4'h0, 32'hFFFF_FFFF, g);
    exp_rsp(1'b0, 32'h0, 1'b0, g, 6);
    wait_done(50);

    // Read with slave error, one wait state.
    exp_apb(32'h1A10_5000, 1'b0, 1'b0, 32'h0, 1, 32'hDEAD_0000, 1'b1);
    issue(32'h1A10_5000, 1'b0, 4'hF, 32'h0, g);
    exp_rsp(1'b0, 32'h0, 1'b1, g, 4);
    wait_done(50);

    // RMW whose read phase errors: no write phase, rvalid at c3 with err.
    exp_apb(32'h1A10_6000, 1'b0, 1'b0, 32'h0, 0, 32'h0, 1'b1);
    issue(32'h1A10_6000, 1'b1, 4'b0001, 32'h0000_00AA, g);
    exp_rsp(1'b0, 32'h0, 1'b1, g, 3);
    wait_done(50);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check1("rmw_err_no_psel", psel_o, 1'b0);
    end
    @(posedge clk);
    #1;

    // Back-to-back reads: second request held, granted 4 cycles after the first.
    exp_apb(32'h1A10_7000, 1'b0, 1'b0, 32'h0, 0, 32'hA5A5_A5A5, 1'b0);
    exp_apb(32'h1A10_7004, 1'b0, 1'b0, 32'h0, 0, 32'h0F0F_0F0F, 1'b0);
    issue(32'h1A10_7000, 1'b0, 4'hF, 32'h0, g1);
    exp_rsp(1'b1, 32'hA5A5_A5A5, 1'b0, g1, 3);
    issue(32'h1A10_7004, 1'b0, 4'hF, 32'h0, g2);
    exp_rsp(1'b1, 32'h0F0F_0F0F, 1'b0, g2, 3);
    check32("b2b_spacing", 32'(g2 - g1), 32'd4);
    wait_done(50);

    // Slave never answers: still in ACCESS after 1000 cycles, then async reset.
    hang_mode = 1'b1;
    issue(32'h1A10_8000, 1'b0, 4'hF, 32'h0, g);
    repeat (1000) @(negedge clk);
    check1("hang_psel", psel_o, 1'b1);
    check1("hang_penable", penable_o, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check1("async_rst_psel", psel_o, 1'b0);
    check1("async_rst_penable", penable_o, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    hang_mode = 1'b0;
    @(posedge clk);
    #1;

    // Normal read after reset release.
    exp_apb(32'h1A10_9000, 1'b0, 1'b0, 32'h0, 0, 32'h600D_F00D, 1'b0);
    issue(32'h1A10_9000, 1'b0, 4'hF, 32'h0, g);
    exp_rsp(1'b1, 32'h600D_F00D, 1'b0, g, 3);
    wait_done(50);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
